// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared types for the RV32IM pipeline stage registers.
//   id_ex_t    - packed ID/EX payload (operands, immediate, register
//                indices, control bits), carried opaquely by pipe_stage_skid
//   ID_EX_W    - payload width in bits
//   ID_EX_NOP  - bubble value; all control bits clear, so nothing writes back
package rv_pipe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        is_branch;
        logic        alu_src;
        logic [1:0]  a_sel;
        logic [4:0]  alu_op;
        logic        reg_write;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch_unsigned;
        logic        mult_start;
    } id_ex_t;

    localparam int     ID_EX_W   = $bits(id_ex_t);
    localparam id_ex_t ID_EX_NOP = '0;

endpackage

// File: rtl/pipe_stage_stats.sv
// pipe_stage_stats: two saturating 32-bit event counters for a pipeline stage.
// Ports:
//   clk, rst            - clock, synchronous active-high reset (clears counters)
//   out_valid/out_ready - downstream handshake being observed
//   stall_cnt           - cycles with out_valid & !out_ready
//   bubble_cnt          - cycles with !out_valid
// Only built when PIPE_STAGE_STATS_EN is defined. Flush does not reach here.
module pipe_stage_stats
    import rv_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
);

    logic [31:0] stall_q,  stall_d;
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (rst) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (out_valid && !out_ready && stall_q != 32'hFFFF_FFFF)
                stall_d = stall_q + 32'd1;
            if (!out_valid && bubble_q != 32'hFFFF_FFFF)
                bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        stall_q  <= stall_d;
        bubble_q <= bubble_d;
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic pipeline stage register with valid/ready handshake
// and a 2-entry skid buffer (main + skid), so in_ready comes straight from a
// flop and never depends combinationally on out_ready.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   flush                 - synchronous kill of all held entries (same as rst)
//   in_valid/in_ready     - upstream handshake; in_ready is registered
//   in_data               - upstream payload (DATA_W bits)
//   out_valid/out_ready   - downstream handshake
//   out_data              - presented payload, NOP_VAL while out_valid=0
//   occupancy             - held entries, 0..2
//   stall_cnt, bubble_cnt - only with PIPE_STAGE_STATS_EN defined
module pipe_stage_skid
    import rv_pipe_pkg::*;
#(
    parameter int                DATA_W  = 160,
    parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_d_q, main_d_d;
    logic [DATA_W-1:0] skid_d_q, skid_d_d;
    logic              in_ready_q, in_ready_d;

    logic in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_v_q & out_ready;

    // The valid pair {main_v, skid_v} is the state: 00 EMPTY, 10 HALF, 11 FULL.
    // Vacated slots are rewritten with NOP_VAL so out_data needs no mux.
    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d_d = main_d_q;
        skid_d_d = skid_d_q;
        if (rst || flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            main_d_d = NOP_VAL;
            skid_d_d = NOP_VAL;
        end else begin
            unique case ({main_v_q, skid_v_q})
                2'b00: begin
                    if (in_fire) begin
                        main_v_d = 1'b1;
                        main_d_d = in_data;
                    end
                end
                2'b10: begin
                    if (out_fire && in_fire) begin
                        main_d_d = in_data;
                    end else if (out_fire) begin
                        main_v_d = 1'b0;
                        main_d_d = NOP_VAL;
                    end else if (in_fire) begin
                        skid_v_d = 1'b1;
                        skid_d_d = in_data;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        main_d_d = skid_d_q;
                        skid_v_d = 1'b0;
                        skid_d_d = NOP_VAL;
                    end
                end
                default: begin
                    // 01 is unreachable; fold it back to EMPTY.
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                    main_d_d = NOP_VAL;
                    skid_d_d = NOP_VAL;
                end
            endcase
        end
        in_ready_d = ~skid_v_d;
    end

    always_ff @(posedge clk) begin
        main_v_q   <= main_v_d;
        skid_v_q   <= skid_v_d;
        main_d_q   <= main_d_d;
        skid_d_q   <= skid_d_d;
        in_ready_q <= in_ready_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_data  = main_d_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .out_valid  (main_v_q),
        .out_ready  (out_ready),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline stage register for the RV32IM core; successor to the fixed-field per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload bus (packed stage struct) with a valid/ready handshake and a 2-entry skid buffer, so back-pressure (e.g. the multi-cycle multiplier busy) never needs a combinational ready path.
- Synchronous flush turns the stage into a bubble (NOP).

Parameters:
- DATA_W, 160, width of the packed payload (pc, operands, imm, reg indices, control).
- NOP_VAL, '0 (DATA_W bits), payload value presented while the stage holds a bubble.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous kill of all held entries (branch mispredict / jump).
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; driven directly from a flop.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage presents a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  presented payload; equals NOP_VAL when out_valid=0.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Storage: main register (main_v, main_d) drives out_*; skid register (skid_v, skid_d).
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_v, registered. occupancy = main_v + skid_v.
- Reset (rst=1):
  - main_v=0, skid_v=0, main_d=NOP_VAL, skid_d=NOP_VAL.
  - in_ready=1, out_valid=0, out_data=NOP_VAL, occupancy=0.
- States (encoded by the valid bits):
  - EMPTY: main_v=0, skid_v=0.
  - HALF: main_v=1, skid_v=0.
  - FULL: main_v=1, skid_v=1.
- EMPTY:
  - in_fire → HALF; main_d=in_data.
- HALF:
  - out_fire & in_fire → HALF; main_d=in_data (pass-through, 1 payload/cycle).
  - out_fire & !in_fire → EMPTY; main_d=NOP_VAL.
  - !out_fire & in_fire → FULL; skid_d=in_data; main unchanged.
  - Otherwise hold.
- FULL (in_ready=0, so no in_fire):
  - out_fire → HALF; main_d=skid_d, skid_d=NOP_VAL.
  - Otherwise hold.
- Latency: in_fire at cycle N, payload visible on out_data at N+1 when the stage is EMPTY or HALF-with-out_fire.
- Ordering: strictly FIFO; never drops or duplicates a payload except on flush/rst.
- Flush:
  - Same effect as reset on all state.
  - Priority over both handshakes in that cycle: an in_fire coinciding with flush is discarded, and an out_fire in that cycle still counts downstream.
  - in_ready=1 on the next cycle.
- Priority: rst = flush > handshake logic.
- out_data/out_valid hold stable while out_valid=1 & out_ready=0; they change only on out_fire, flush or rst.
- in_valid with in_ready=0: input ignored; upstream must hold.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- Defined: adds output ports stall_cnt [31:0] and bubble_cnt [31:0].
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with !out_valid.
  - Both are saturating at 32'hFFFF_FFFF, cleared by rst only (not flush), and update in the same cycle as the condition, visible the next cycle.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package rv_pipe_pkg:
  - typedef id_ex_t packed struct (pc, rs1/rs2 data, imm, rs1/rs2/rd, funct3, is_branch, alu_src, a_sel, alu_op, reg_write, mem_write, mem_to_reg, branch_unsigned, mult_start).
  - localparam ID_EX_W = $bits(id_ex_t).
  - localparam id_ex_t ID_EX_NOP.
- Instantiations set DATA_W=ID_EX_W, NOP_VAL=ID_EX_NOP.
- Optional sub-module pipe_stage_stats (two saturating counters) under the macro; the skid logic stays in one module.

Test Plan:
1. Reset, then in_valid=1 with data 0x…A5 for 1 cycle, out_ready=1 → out_valid=1 with 0x…A5 one cycle later, occupancy 1, then EMPTY.
2. Streaming 0,1,2,3 back-to-back with out_ready=1 → outputs 0,1,2,3 on consecutive cycles, in_ready stays 1.
3. Send 10,11,12 with out_ready=0 → 10 held on out_data, 11 in skid, in_ready=0 after 2nd accept, 12 held upstream. Raise out_ready → 10,11,12 in order, no loss.
4. FULL with 20,21, pulse flush with in_valid=1 data 22 → next cycle out_valid=0, out_data=NOP_VAL, occupancy 0, in_ready=1; 22 never appears.
5. rst asserted while FULL, with in_valid=1 → identical to 4; with PIPE_STAGE_STATS_EN, stall_cnt=bubble_cnt=0.
6. PIPE_STAGE_STATS_EN: hold out_valid=1, out_ready=0 for 5 cycles → stall_cnt=5; flush then does not clear stall_cnt; force stall_cnt=32'hFFFF_FFFE, stall 3 cycles → saturates at 32'hFFFF_FFFF.
